reg_bus_ctrl: RTL and testbench



---
 rtl/reg_bus_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_reg_bus_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_ctrl.sv
// Host-side register bus master: decodes 4-byte command frames into register
// writes/reads on the shared bus and streams read data back as two bytes.
module reg_bus_ctrl #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [3:0]  reg_mod_o,
  output logic [7:0]  reg_addr_o,
  output logic [15:0] reg_data_o,
  output logic        reg_we_o,
  input  logic [15:0] reg_data_i,
  output logic [7:0]  err_cnt_o
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned MOD_W  = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ERR_W  = 8;

  localparam logic [MOD_W-1:0]  LOCAL_MOD = MOD_W'(15);
  localparam logic [DATA_W-1:0] LOCAL_ID  = DATA_W'(16'hF001);
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

  typedef enum logic [2:0] {
    RX0, RX1, RX2, RX3, EXEC, RD, TX_HI, TX_LO
  } state_t;

  state_t state_q, state_d;

  logic [BYTE_W-1:0] hdr_q, hdr_d;
  logic [BYTE_W-1:0] addr_q, addr_d;
  logic [BYTE_W-1:0] dhi_q, dhi_d;
  logic [CNT_W-1:0]  tmo_q, tmo_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [ERR_W-1:0]  err_q, err_d;

  logic              rx_ready_q, rx_ready_d;
  logic              tx_valid_q, tx_valid_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic [MOD_W-1:0]  reg_mod_q, reg_mod_d;
  logic [BYTE_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] reg_data_q, reg_data_d;
  logic              reg_we_q, reg_we_d;

  logic              accept_c;
  logic              is_write_c;
  logic              bad_c;
  logic              local_c;
  logic              timeout_c;
  logic [DATA_W-1:0] local_rd_c;
  logic [DATA_W-1:0] rd_val_c;
  logic              err_inc_c;
  logic              err_clr_c;

  // Frame header decode; the header byte is held for the whole frame.
  assign accept_c   = rx_valid_i & rx_ready_q;
  assign is_write_c = hdr_q[7];
  assign bad_c      = |hdr_q[6:4];
  assign local_c    = (hdr_q[3:0] == LOCAL_MOD);
  assign local_rd_c = (addr_q == '0) ? {BYTE_W'(0), err_q} : LOCAL_ID;
  assign rd_val_c   = local_c ? local_rd_c : reg_data_i;
  assign timeout_c  = (TIMEOUT != 0) && (tmo_q == CNT_W'(TIMEOUT - 1));

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    addr_d     = addr_q;
    dhi_d      = dhi_q;
    tmo_d      = tmo_q;
    shadow_d   = shadow_q;
    tx_data_d  = tx_data_q;
    reg_mod_d  = reg_mod_q;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    reg_we_d   = 1'b0;
    err_inc_c  = 1'b0;
    err_clr_c  = 1'b0;
    err_d      = err_q;
    rx_ready_d = 1'b0;
    tx_valid_d = 1'b0;

    case (state_q)
      RX0: begin
        tmo_d = '0;
        if (accept_c) begin
          hdr_d   = rx_data_i;
          state_d = RX1;
        end
      end
      RX1, RX2, RX3: begin
        if (accept_c) begin
          tmo_d = '0;
          case (state_q)
            RX1: begin
              addr_d  = rx_data_i;
              state_d = RX2;
            end
            RX2: begin
              dhi_d   = rx_data_i;
              state_d = RX3;
            end
            default: begin
              state_d = EXEC;
              // Bus outputs only move for real accesses to external modules.
              if (!bad_c && !local_c) begin
                reg_mod_d  = hdr_q[3:0];
                reg_addr_d = addr_q;
                reg_data_d = {dhi_q, rx_data_i};
                reg_we_d   = is_write_c;
              end
            end
          endcase
        end else if (timeout_c) begin
          tmo_d     = '0;
          err_inc_c = 1'b1;
          state_d   = RX0;
        end else if (TIMEOUT != 0) begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      EXEC: begin
        if (bad_c) begin
          err_inc_c = 1'b1;
          state_d   = RX0;
        end else if (is_write_c) begin
          err_clr_c = local_c && (addr_q == '0);
          state_d   = RX0;
        end else begin
          state_d = RD;
        end
      end
      RD: begin
        shadow_d  = rd_val_c;
        tx_data_d = rd_val_c[15:8];
        state_d   = TX_HI;
      end
      TX_HI: begin
        if (tx_ready_i) begin
          tx_data_d = shadow_q[7:0];
          state_d   = TX_LO;
        end
      end
      TX_LO: begin
        if (tx_ready_i) begin
          state_d = RX0;
        end
      end
      default: state_d = RX0;
    endcase

    // Clear has priority over increment; increment saturates.
    if (err_clr_c) begin
      err_d = '0;
    end else if (err_inc_c && (err_q != ERR_MAX)) begin
      err_d = err_q + ERR_W'(1);
    end

    rx_ready_d = (state_d == RX0) || (state_d == RX1) ||
                 (state_d == RX2) || (state_d == RX3);
    tx_valid_d = (state_d == TX_HI) || (state_d == TX_LO);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= RX0;
      hdr_q      <= '0;
      addr_q     <= '0;
      dhi_q      <= '0;
      tmo_q      <= '0;
      shadow_q   <= '0;
      err_q      <= '0;
      rx_ready_q <= 1'b1;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      reg_mod_q  <= '0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
      reg_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      addr_q     <= addr_d;
      dhi_q      <= dhi_d;
      tmo_q      <= tmo_d;
      shadow_q   <= shadow_d;
      err_q      <= err_d;
      rx_ready_q <= rx_ready_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      reg_mod_q  <= reg_mod_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
      reg_we_q   <= reg_we_d;
    end
  end

  assign rx_ready_o = rx_ready_q;
  assign tx_valid_o = tx_valid_q;
  assign tx_data_o  = tx_data_q;
  assign reg_mod_o  = reg_mod_q;
  assign reg_addr_o = reg_addr_q;
  assign reg_data_o = reg_data_q;
  assign reg_we_o   = reg_we_q;
  assign err_cnt_o  = err_q;

endmodule

// File: tb/tb_reg_bus_ctrl.sv
// Directed bench for reg_bus_ctrl: a table of frames with hand-computed bus
// and response results, plus sequences for latency, backpressure, timeout,
// counter saturation and mid-response reset.
module tb_reg_bus_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  reg_mod;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_we;
  logic [15:0] reg_rdata;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  int         we_cnt;
  logic [7:0] tx_q[$];

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [15:0] rd_data;
    int          exp_we;
    logic [3:0]  exp_mod;
    logic [7:0]  exp_addr;
    logic [15:0] exp_wdata;
    int          exp_ntx;
    logic [15:0] exp_rsp;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t vecs[12];

  reg_bus_ctrl #(.TIMEOUT(20)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .rx_ready_o (rx_ready),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .reg_mod_o  (reg_mod),
    .reg_addr_o (reg_addr),
    .reg_data_o (reg_wdata),
    .reg_we_o   (reg_we),
    .reg_data_i (reg_rdata),
    .err_cnt_o  (err_cnt)
  );

  always #5 clk_i = ~clk_i;

  // Records write strobes and completed response-byte handshakes.
  always @(negedge clk_i) begin
    if (reg_we === 1'b1) we_cnt++;
    if (tx_valid === 1'b1 && tx_ready === 1'b1) tx_q.push_back(tx_data);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (rx_ready !== 1'b1) chk("rx_ready_wait", 32'(rx_ready), 32'd1);
    step();
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (rx_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("return_to_rx0", 32'(rx_ready), 32'd1);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    reg_rdata = v.rd_data;
    tx_ready  = 1'b1;
    we_cnt    = 0;
    tx_q.delete();
    send_byte(v.b0);
    send_byte(v.b1);
    send_byte(v.b2);
    send_byte(v.b3);
    wait_idle();
    chk({name, "_we_count"}, 32'(we_cnt), 32'(v.exp_we));
    if (v.exp_we != 0) begin
      chk({name, "_mod"}, 32'(reg_mod), 32'(v.exp_mod));
      chk({name, "_addr"}, 32'(reg_addr), 32'(v.exp_addr));
      chk({name, "_wdata"}, 32'(reg_wdata), 32'(v.exp_wdata));
    end
    chk({name, "_tx_count"}, 32'(tx_q.size()), 32'(v.exp_ntx));
    if (v.exp_ntx == 2 && tx_q.size() == 2) begin
      chk({name, "_rsp"}, 32'({tx_q[0], tx_q[1]}), 32'(v.exp_rsp));
    end
    chk({name, "_err"}, 32'(err_cnt), 32'(v.exp_err));
  endtask

  initial begin
    int   n;
    int   held;
    vec_t v;

    // b0, b1, b2, b3, rd_data, we, mod, addr, wdata, ntx, rsp, err
    vecs[0]  = '{8'h81, 8'h18, 8'hAB, 8'hCD, 16'h0000, 1, 4'h1, 8'h18, 16'hABCD, 0, 16'h0000, 8'd0};
    vecs[1]  = '{8'h01, 8'h19, 8'h00, 8'h00, 16'h0002, 0, 4'h0, 8'h00, 16'h0000, 2, 16'h0002, 8'd0};
    vecs[2]  = '{8'h90, 8'h12, 8'h34, 8'h56, 16'h0000, 0, 4'h0, 8'h00, 16'h0000, 0, 16'h0000, 8'd1};
    vecs[3]  = '{8'h0F, 8'h00, 8'h00, 8'h00, 16'h5555, 0, 4'h0, 8'h00, 16'h0000, 2, 16'h0001, 8'd1};
    vecs[4]  = '{8'h0F, 8'h05, 8'h00, 8'h00, 16'h5555, 0, 4'h0, 8'h00, 16'h0000, 2, 16'hF001, 8'd1};
    vecs[5]  = '{8'h8F, 8'h05, 8'h12, 8'h34, 16'h0000, 0, 4'h0, 8'h00, 16'h0000, 0, 16'h0000, 8'd1};
    vecs[6]  = '{8'hF3, 8'h44, 8'h55, 8'h66, 16'h0000, 0, 4'h0, 8'h00, 16'h0000, 0, 16'h0000, 8'd2};
    vecs[7]  = '{8'h0F, 8'h00, 8'hFF, 8'hFF, 16'h0000, 0, 4'h0, 8'h00, 16'h0000, 2, 16'h0002, 8'd2};
    vecs[8]  = '{8'h8F, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 4'h0, 8'h00, 16'h0000, 0, 16'h0000, 8'd0};
    vecs[9]  = '{8'h0F, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 4'h0, 8'h00, 16'h0000, 2, 16'h0000, 8'd0};
    vecs[10] = '{8'h8E, 8'h7F, 8'hFF, 8'hFF, 16'h0000, 1, 4'hE, 8'h7F, 16'hFFFF, 0, 16'h0000, 8'd0};
    vecs[11] = '{8'h0E, 8'h80, 8'h12, 8'h34, 16'hA55A, 0, 4'h0, 8'h00, 16'h0000, 2, 16'hA55A, 8'd0};

    rst_n_i   = 1'b0;
    rx_data   = '0;
    rx_valid  = 1'b0;
    tx_ready  = 1'b0;
    reg_rdata = '0;
    we_cnt    = 0;

    #12;
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_bus", 32'({reg_mod, reg_addr, reg_wdata, reg_we}), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    #5 rst_n_i = 1'b1;
    step();

    for (int i = 0; i < 12; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Write latency: strobe in the cycle after B3, ready again the cycle after that.
    tx_ready = 1'b1;
    send_byte(8'h83); send_byte(8'h21); send_byte(8'h00);
    send_byte(8'h7E);
    chk("wlat_we_n1", 32'(reg_we), 32'd1);
    chk("wlat_rdy_n1", 32'(rx_ready), 32'd0);
    chk("wlat_bus_n1", 32'({reg_mod, reg_addr, reg_wdata}), 32'({4'h3, 8'h21, 16'h007E}));
    step();
    chk("wlat_we_n2", 32'(reg_we), 32'd0);
    chk("wlat_rdy_n2", 32'(rx_ready), 32'd1);

    // Read latency: tx_valid first seen three cycles after B3 is accepted.
    reg_rdata = 16'h0002;
    send_byte(8'h01); send_byte(8'h19); send_byte(8'h00);
    send_byte(8'h00);
    chk("rlat_n1", 32'({reg_we, tx_valid, rx_ready}), 32'd0);
    step();
    chk("rlat_n2", 32'({reg_we, tx_valid, rx_ready}), 32'd0);
    chk("rlat_bus_n2", 32'({reg_mod, reg_addr}), 32'({4'h1, 8'h19}));
    step();
    chk("rlat_n3", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h00}));
    step();
    chk("rlat_n4", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h02}));
    step();
    chk("rlat_n5", 32'({tx_valid, rx_ready}), 32'({1'b0, 1'b1}));

    // Backpressure: high byte must hold for ten stalled cycles.
    tx_ready  = 1'b0;
    reg_rdata = 16'hF001;
    send_byte(8'h02); send_byte(8'h44); send_byte(8'h00); send_byte(8'h00);
    n = 0;
    while (tx_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    held = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx_valid === 1'b1 && tx_data === 8'hF0) held++;
      step();
    end
    chk("bp_hold_cycles", 32'(held), 32'd10);
    tx_ready = 1'b1;
    step();
    chk("bp_lo", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h01}));
    step();
    chk("bp_done", 32'({tx_valid, rx_ready}), 32'({1'b0, 1'b1}));

    // Inter-byte timeout (TIMEOUT=20) discards a partial frame.
    send_byte(8'h81);
    send_byte(8'h22);
    for (int i = 0; i < 19; i++) step();
    chk("tmo_before", 32'(err_cnt), 32'd0);
    step(); step();
    chk("tmo_after", 32'(err_cnt), 32'd1);
    chk("tmo_rx0", 32'(rx_ready), 32'd1);
    for (int i = 0; i < 30; i++) step();
    chk("tmo_idle_rx0", 32'(err_cnt), 32'd1);
    v = '{8'h82, 8'h10, 8'h12, 8'h34, 16'h0000, 1, 4'h2, 8'h10, 16'h1234, 0, 16'h0000, 8'd1};
    run_vec("tmo_write", v);
    v = '{8'h8F, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 4'h0, 8'h00, 16'h0000, 0, 16'h0000, 8'd0};
    run_vec("tmo_clear", v);

    // Error counter saturates at 255.
    for (int i = 0; i < 258; i++) begin
      send_byte(8'h90); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    end
    wait_idle();
    step();
    chk("err_saturate", 32'(err_cnt), 32'd255);

    // Reset during TX_LO drops tx_valid immediately and clears all outputs.
    tx_ready  = 1'b0;
    reg_rdata = 16'h1234;
    send_byte(8'h01); send_byte(8'h19); send_byte(8'h00); send_byte(8'h00);
    n = 0;
    while (tx_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("rst_seq_hi", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h12}));
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    chk("rst_seq_lo", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h34}));
    #2 rst_n_i = 1'b0;
    #1;
    chk("arst_tx_valid", 32'(tx_valid), 32'd0);
    chk("arst_tx_data", 32'(tx_data), 32'd0);
    chk("arst_rx_ready", 32'(rx_ready), 32'd1);
    chk("arst_bus", 32'({reg_mod, reg_addr, reg_wdata, reg_we}), 32'd0);
    chk("arst_err", 32'(err_cnt), 32'd0);
    #3 rst_n_i = 1'b1;
    v = '{8'h85, 8'h01, 8'hBE, 8'hEF, 16'h0000, 1, 4'h5, 8'h01, 16'hBEEF, 0, 16'h0000, 8'd0};
    run_vec("post_rst_write", v);
    v = '{8'h0F, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 4'h0, 8'h00, 16'h0000, 2, 16'h0000, 8'd0};
    run_vec("post_rst_read", v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
